pc_fetch_unit: RTL

- Program-counter and fetch-control stage directly upstream of the instruction memory.
- Holds the PC and drives the combinational `readAddr` into the asynchronous-read instruction memory; the returned `inst` is passed through to decode, tagged with its PC.
- Selects the next PC: sequential, branch, or JALR. Supports stall.
- Detects EBREAK, misaligned targets and out-of-range targets, and halts cleanly on any of them.

---
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch control ahead of an async-read instruction memory.
//   clk, rst               rising-edge clock, synchronous active-high reset
//   stall                  hold PC and suppress accept this cycle
//   branchTaken/Target     branch/JAL redirect taken at the accept edge
//   jalrTaken/Target       JALR redirect (bit 0 cleared here), wins over branch
//   readAddr               byte address to instruction memory (= PC)
//   inst                   instruction word returned by memory
//   instOut, pcOut         instruction (NOP when not valid) and its PC, to decode
//   pcPlus4                pcOut + 4 for link writeback
//   valid, halted          fetch live / fetch stopped
//   misaligned, outOfRange sticky halt causes
//   instCount              number of accepted instructions
module pc_fetch_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_0000),
    parameter int unsigned      IMEM_DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchTarget,
    input  logic             jalrTaken,
    input  logic [WIDTH-1:0] jalrTarget,
    output logic [WIDTH-1:0] readAddr,
    input  logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] instOut,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] pcPlus4,
    output logic             valid,
    output logic             halted,
    output logic             misaligned,
    output logic             outOfRange,
    output logic [31:0]      instCount
);

    // One past the last legal byte address; one extra bit so it never overflows.
    localparam logic [WIDTH:0]   IMEM_BYTES = (WIDTH+1)'(IMEM_DEPTH * 4);
    localparam logic [WIDTH-1:0] NOP_WORD   = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] EBREAK_W   = WIDTH'(32'h0010_0073);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic             valid_q;
    logic             halted_q;
    logic             mis_q;
    logic             oor_q;
    logic [31:0]      count_q;

    logic [WIDTH:0]   seq_sum;
    logic [WIDTH-1:0] jalr_tgt;
    logic [WIDTH-1:0] next_pc;
    logic             next_wrap;
    logic             tgt_misaligned;
    logic             tgt_oor;
    logic             is_ebreak;

    // Sequential PC computed one bit wider so a wrap past 2^WIDTH is visible.
    assign seq_sum  = {1'b0, pc} + (WIDTH+1)'(4);
    assign jalr_tgt = {jalrTarget[WIDTH-1:1], 1'b0};

    // Next-PC select: JALR > branch > sequential; only the winner is checked.
    always_comb begin
        next_pc   = seq_sum[WIDTH-1:0];
        next_wrap = seq_sum[WIDTH];
        if (jalrTaken) begin
            next_pc   = jalr_tgt;
            next_wrap = 1'b0;
        end else if (branchTaken) begin
            next_pc   = branchTarget;
            next_wrap = 1'b0;
        end
    end

    assign tgt_misaligned = (next_pc[1:0] != 2'b00);
    assign tgt_oor        = next_wrap || ({1'b0, next_pc} >= IMEM_BYTES);
    assign is_ebreak      = (inst == EBREAK_W);

    // Fetch FSM with PC, counter and sticky fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            oor_q    <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    state   <= S_RUN;
                    valid_q <= 1'b1;
                end
                S_RUN: begin
                    if (!stall) begin
                        count_q <= count_q + 32'd1;
                        if (is_ebreak) begin
                            state    <= S_HALT;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end else if (tgt_misaligned) begin
                            state    <= S_HALT;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            mis_q    <= 1'b1;
                        end else if (tgt_oor) begin
                            state    <= S_HALT;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            oor_q    <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                S_HALT: begin
                    state    <= S_HALT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= S_HALT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign readAddr   = pc;
    assign pcOut      = pc;
    assign pcPlus4    = seq_sum[WIDTH-1:0];
    assign instOut    = valid_q ? inst : NOP_WORD;
    assign valid      = valid_q;
    assign halted     = halted_q;
    assign misaligned = mis_q;
    assign outOfRange = oor_q;
    assign instCount  = count_q;

endmodule
